// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ALUOp.
// ALUOp codes are consumed unchanged by the ALU control stage.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_NONE  = 3'b000;
  localparam logic [2:0] ALU_RTYPE = 3'b111;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b011;

  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    nxt = S_TRAP;
    case (op)
      OP_RTYPE:       nxt = S_REXEC;
      OP_LW, OP_SW:   nxt = S_MEMADR;
      OP_ADDI,
      OP_ORI,
      OP_LUI:         nxt = S_IEXEC;
      OP_BEQ:         nxt = S_BRANCH;
`ifdef MC_BNE_EN
      OP_BNE:         nxt = S_BRANCH;
`endif
      OP_J:           nxt = S_JUMP;
      default:        nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Counts consecutive memory wait cycles; expired once the count
// reaches MEM_TIMEOUT.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 8'hff)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q >= 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM with memory timeout trap.
// Optional MC_BNE_EN: bne decodes to BRANCH and loads the PC on zero=0.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic [3:0] state,
  output logic       error
);

  state_e state_q, state_d;
  logic   mem_st;
  logic   expired;
  logic   clr;
  logic   inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_st      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = ALU_NONE;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        mem_st  = 1'b1;
        // timeout wins even if memory answers in the same cycle
        if (expired) begin
          state_d = S_TRAP;
        end else if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
        state_d = decode_next(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        mem_st  = 1'b1;
        if (expired)        state_d = S_TRAP;
        else if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        mem_st   = 1'b1;
        if (expired)        state_d = S_TRAP;
        else if (mem_ready) state_d = S_FETCH;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_RTYPE;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
        if (opcode == OP_ORI) ALUOp = ALU_OR;
        if (opcode == OP_LUI) ALUOp = ALU_LUI;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        PCSource    = 2'b01;
        PCWriteCond = zero;
`ifdef MC_BNE_EN
        if (opcode == OP_BNE) PCWriteCond = ~zero;
`endif
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  assign clr = mem_ready | (state_d != state_q);
  assign inc = mem_st & ~mem_ready;

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .inc    (inc),
    .expired(expired)
  );

  assign state = state_q;
  assign error = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level trace model
// pushes per-cycle expectations, a negedge monitor compares.
module tb_multicycle_control;

  localparam int T = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic       error;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   zmode = -1;
  bit   trapped = 0;

  multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .state(state), .error(error)
  );

  always #5 clk = ~clk;

  // Expected outputs from the state table, state given by number
  function automatic exp_t model(int st, logic [5:0] op, logic z,
                                 logic mr, bit ex);
    exp_t e;
    logic taken;
    e = '0;
    e.st = 4'(st);
    case (st)
      0: begin
        e.mrd = 1; e.asb = 2'b01; e.aop = 3'b100;
        e.irw = mr && !ex; e.pcw = mr && !ex;
      end
      1: begin e.asb = 2'b11; e.aop = 3'b100; end
      2: begin e.asa = 1; e.asb = 2'b10; e.aop = 3'b100; end
      3: begin e.mrd = 1; e.iord = 1; end
      4: begin e.rw = 1; e.m2r = 1; end
      5: begin e.mwr = 1; e.iord = 1; end
      6: begin e.asa = 1; e.aop = 3'b111; end
      7: begin e.rw = 1; e.rdst = 1; end
      8: begin
        e.asa = 1; e.asb = 2'b10;
        e.aop = (op == 6'b001101) ? 3'b101 :
                (op == 6'b001111) ? 3'b011 : 3'b100;
      end
      9: e.rw = 1;
      10: begin
        taken = z;
`ifdef MC_BNE_EN
        if (op == 6'b000101) taken = !z;
`endif
        e.pcs = 2'b01; e.pcwc = taken;
      end
      11: begin e.pcw = 1; e.pcs = 2'b10; end
      12: e.err = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
            MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
            ALUOp, error};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL out cyc=%0d got=%h exp=%h (state got %0d exp %0d)",
                 cyc, g, e, g.st, e.st);
      end
      cyc++;
    end
  end

  task automatic emit(int st, logic mr, bit ex);
    mem_ready = mr;
    zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
    q.push_back(model(st, opcode, zero, mr, ex));
    @(posedge clk);
    #1;
  endtask

  task automatic emit_r(int st);
    emit(st, 1'($urandom), 1'b0);
  endtask

  // Memory wait: low for `stall` cycles, then ready; trap at timeout
  task automatic mem_phase(int st, int stall);
    for (int i = 0; i <= T; i++) begin
      bit mr, ex;
      mr = (i == stall);
      ex = (i == T);
      emit(st, mr, ex);
      if (ex) begin
        trapped = 1;
        return;
      end
      if (mr) return;
    end
  endtask

  task automatic run_instr(logic [5:0] op, int fs, int ms);
    opcode = op;
    mem_phase(0, fs);
    if (trapped) return;
    emit_r(1);
    case (op)
      6'b000000: begin emit_r(6); emit_r(7); end
      6'b100011: begin
        emit_r(2);
        mem_phase(3, ms);
        if (!trapped) emit_r(4);
      end
      6'b101011: begin emit_r(2); mem_phase(5, ms); end
      6'b001000, 6'b001101, 6'b001111: begin emit_r(8); emit_r(9); end
      6'b000100: emit_r(10);
`ifdef MC_BNE_EN
      6'b000101: emit_r(10);
`endif
      6'b000010: emit_r(11);
      default: trapped = 1;
    endcase
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    mem_ready = 1'($urandom);
    zero = 1'($urandom);
    q.push_back(model(0, opcode, zero, mem_ready, 1'b0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    trapped = 0;
  endtask

  task automatic trap_and_reset();
    if (trapped) begin
      repeat (3) emit_r(12);
      reset_pulse();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [9];
    logic [5:0] op;
    int fs, ms;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0d, 6'h0f, 6'h04, 6'h05, 6'h02};
    reset = 1'b0;
    opcode = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse();
    reset_pulse();

    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    zmode = 0; run_instr(6'b000100, 0, 0);
    zmode = 1; run_instr(6'b000100, 0, 0);
    zmode = -1;
    run_instr(6'b001101, 1, 0);
    run_instr(6'b001111, 0, 0);
    run_instr(6'b101011, 0, 2);
    run_instr(6'b000010, 2, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b100011, T - 1, T - 1);

    run_instr(6'b100011, 40, 0);
    trap_and_reset();
    run_instr(6'b101011, 0, T);
    trap_and_reset();
    run_instr(6'b111111, 0, 0);
    trap_and_reset();
    zmode = 0; run_instr(6'b000101, 0, 0);
    zmode = -1;
    trap_and_reset();

    opcode = 6'b100011;
    mem_phase(0, 0);
    emit_r(1);
    emit_r(2);
    emit(3, 1'b0, 1'b0);
    reset_pulse();
    run_instr(6'b000000, 0, 0);

    for (int n = 0; n < 80; n++) begin
      int k;
      k = $urandom_range(0, 9);
      op = (k == 9) ? 6'($urandom) : ops[k];
      fs = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 2)
                                       : $urandom_range(0, 3);
      ms = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 2)
                                       : $urandom_range(0, 3);
      run_instr(op, fs, ms);
      trap_and_reset();
    end

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
